mega_demux_of_fate: RTL and testbench

Registered 1-to-8 demultiplexer for 32-bit words with valid/ready handshakes on the input and on each of eight output lanes. It is the distributing counterpart of the 8:1 MegaMuxOfDestiny: a word tagged with a 3-bit select is steered into the matching lane's single-entry holding register, or broadcast to all lanes. It sits between the ALU result path and the eight downstream consumers, and provides backpressure per lane.

---
 rtl/mega_demux_of_fate_if.sv | 30 +++
 rtl/mega_demux_of_fate.sv | 93 +++++++++
 tb/tb_mega_demux_of_fate.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/mega_demux_of_fate_if.sv
// mega_demux_of_fate_if
// Bundles the handshake and data signals of the 1-to-8 demultiplexer.
//   in_valid/in_ready/in_sel/in_bcast/in_data : producer side
//   out_valid/out_ready/out_data               : eight consumer lanes
//   xfer_count                                 : accepted-word counter
// Modports: slave = the demux, master = whoever drives it.
interface mega_demux_of_fate_if #(
    parameter int WIDTH = 32,
    parameter int LANES = 8
);
    logic                         in_valid;
    logic                         in_ready;
    logic [2:0]                   in_sel;
    logic                         in_bcast;
    logic [WIDTH-1:0]             in_data;
    logic [LANES-1:0]             out_valid;
    logic [LANES-1:0]             out_ready;
    logic [LANES-1:0][WIDTH-1:0]  out_data;
    logic [7:0]                   xfer_count;

    modport slave (
        input  in_valid, in_sel, in_bcast, in_data, out_ready,
        output in_ready, out_valid, out_data, xfer_count
    );

    modport master (
        output in_valid, in_sel, in_bcast, in_data, out_ready,
        input  in_ready, out_valid, out_data, xfer_count
    );
endinterface

// File: rtl/mega_demux_of_fate.sv
// mega_demux_of_fate
// Registered 1-to-8 demultiplexer. A word is steered into one lane's
// single-entry holding register (in_sel) or into all lanes at once
// (in_bcast, all-or-nothing). Each lane has its own valid/ready handshake.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset
//   bus   : mega_demux_of_fate_if.slave (see interface header)

// One output lane: holding register plus full flag.
module mega_demux_lane #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_ready,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data,
    output logic             o_free
);
    logic             r_valid;
    logic [WIDTH-1:0] r_data;

    // A lane being drained this cycle can take a new word in the same cycle.
    assign o_free  = !r_valid || i_ready;
    assign o_valid = r_valid;
    assign o_data  = r_data;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
        end else if (r_valid && i_ready) begin
            // Drained without refill; data is left as-is.
            r_valid <= 1'b0;
        end
    end
endmodule

module mega_demux_of_fate #(
    parameter int WIDTH = 32,
    parameter int LANES = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    mega_demux_of_fate_if.slave  bus
);
    logic [LANES-1:0]            w_free;
    logic [LANES-1:0]            w_load;
    logic [LANES-1:0]            w_valid;
    logic [LANES-1:0][WIDTH-1:0] w_data;
    logic                        w_in_ready;
    logic                        w_accept;
    logic [7:0]                  r_xfer_count;

    // Broadcast needs every lane free; a steered word needs only its lane.
    assign w_in_ready = bus.in_bcast ? (&w_free) : w_free[bus.in_sel];
    // in_valid gates first so an unknown select while idle cannot reach state.
    assign w_accept   = bus.in_valid && w_in_ready;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        assign w_load[i] = w_accept && (bus.in_bcast || (bus.in_sel == 3'(i)));

        mega_demux_lane #(.WIDTH(WIDTH)) u_lane (
            .clk     (clk),
            .reset   (reset),
            .i_load  (w_load[i]),
            .i_data  (bus.in_data),
            .i_ready (bus.out_ready[i]),
            .o_valid (w_valid[i]),
            .o_data  (w_data[i]),
            .o_free  (w_free[i])
        );
    end

    // Broadcast counts as a single transfer; wraps silently.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_xfer_count <= '0;
        else if (w_accept)
            r_xfer_count <= r_xfer_count + 8'd1;
    end

    assign bus.in_ready   = w_in_ready;
    assign bus.out_valid  = w_valid;
    assign bus.out_data   = w_data;
    assign bus.xfer_count = r_xfer_count;
endmodule

// File: tb/tb_mega_demux_of_fate.sv
module tb_mega_demux_of_fate;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mega_demux_of_fate_if bus ();
    mega_demux_of_fate dut (.clk(clk), .reset(reset), .bus(bus));

    int nvec = 0;
    int nerr = 0;

    // Reference state: which lanes hold a word, their contents, the counter.
    logic [7:0]       mv;
    logic [7:0][31:0] md;
    logic [7:0]       mcnt;

    typedef struct {
        logic        iv;
        logic [2:0]  sel;
        logic        bc;
        logic [31:0] data;
        logic [7:0]  ordy;
        logic        e_irdy;
        logic [7:0]  e_oval;
        logic [7:0]  e_cnt;
        logic [31:0] e_lane;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic iv, input logic [2:0] sel, input logic bc,
                         input logic [31:0] data, input logic [7:0] ordy);
        bus.in_valid  = iv;
        bus.in_sel    = sel;
        bus.in_bcast  = bc;
        bus.in_data   = data;
        bus.out_ready = ordy;
    endtask

    function automatic logic model_irdy();
        logic [7:0] fr;
        fr = ~mv | bus.out_ready;
        return bus.in_bcast ? (fr == 8'hFF) : fr[bus.in_sel];
    endfunction

    task automatic model_reset();
        mv = '0; md = '0; mcnt = '0;
    endtask

    // Apply the block's rules to the reference state for one clock edge.
    task automatic model_edge();
        logic acc;
        acc = bus.in_valid && model_irdy();
        for (int i = 0; i < 8; i++) begin
            if (acc && (bus.in_bcast || bus.in_sel == 3'(i))) begin
                mv[i] = 1'b1;
                md[i] = bus.in_data;
            end else if (mv[i] && bus.out_ready[i]) begin
                mv[i] = 1'b0;
            end
        end
        if (acc) mcnt = mcnt + 8'd1;
    endtask

    // Inputs already driven just after an edge: check in_ready mid-cycle,
    // advance the model at the edge, then check registered state.
    task automatic step(input bit chk_irdy);
        #4;
        if (chk_irdy) chk("in_ready", 256'(bus.in_ready), 256'(model_irdy()));
        @(posedge clk);
        model_edge();
        #1;
        chk("out_valid", 256'(bus.out_valid), 256'(mv));
        chk("out_data", bus.out_data, md);
        chk("xfer_count", 256'(bus.xfer_count), 256'(mcnt));
    endtask

    initial begin
        logic [7:0] c0;
        reset = 1'b1;
        drive(1'b0, 3'd0, 1'b0, 32'h0, 8'h00);
        model_reset();
        #2;
        chk("rst out_valid", 256'(bus.out_valid), 256'h0);
        chk("rst out_data", bus.out_data, 256'h0);
        chk("rst xfer_count", 256'(bus.xfer_count), 256'h0);
        chk("rst in_ready", 256'(bus.in_ready), 256'h1);
        @(posedge clk); #1;
        reset = 1'b0;

        // Steer sweep, broadcast, backpressure, independence, blocked broadcast.
        for (int k = 0; k < 8; k++)
            tbl.push_back('{1'b1, 3'(k), 1'b0, 32'(1) << k, 8'hFF, 1'b1, 8'(1) << k, 8'(k + 1), 32'(1) << k});
        tbl.push_back('{1'b1, 3'd0, 1'b1, 32'hDEADBEEF, 8'hFF, 1'b1, 8'hFF, 8'd9,  32'hDEADBEEF});
        tbl.push_back('{1'b0, 3'd0, 1'b0, 32'h0,        8'hFF, 1'b1, 8'h00, 8'd9,  32'hDEADBEEF});
        tbl.push_back('{1'b1, 3'd3, 1'b0, 32'hA5A5A5A5, 8'h00, 1'b1, 8'h08, 8'd10, 32'hA5A5A5A5});
        tbl.push_back('{1'b1, 3'd3, 1'b0, 32'h5A5A5A5A, 8'h00, 1'b0, 8'h08, 8'd10, 32'hA5A5A5A5});
        tbl.push_back('{1'b1, 3'd3, 1'b0, 32'h5A5A5A5A, 8'h08, 1'b1, 8'h08, 8'd11, 32'h5A5A5A5A});
        tbl.push_back('{1'b1, 3'd5, 1'b0, 32'h12345678, 8'h00, 1'b1, 8'h28, 8'd12, 32'h12345678});
        tbl.push_back('{1'b0, 3'd3, 1'b0, 32'h0,        8'h00, 1'b0, 8'h28, 8'd12, 32'h5A5A5A5A});
        tbl.push_back('{1'b1, 3'd5, 1'b1, 32'hDEADBEEF, 8'h00, 1'b0, 8'h28, 8'd12, 32'h12345678});
        tbl.push_back('{1'b1, 3'd3, 1'b1, 32'hDEADBEEF, 8'h08, 1'b0, 8'h20, 8'd12, 32'h5A5A5A5A});
        tbl.push_back('{1'b0, 3'd5, 1'b0, 32'h0,        8'hFF, 1'b1, 8'h00, 8'd12, 32'h12345678});

        foreach (tbl[n]) begin
            drive(tbl[n].iv, tbl[n].sel, tbl[n].bc, tbl[n].data, tbl[n].ordy);
            #4;
            chk($sformatf("vec%0d in_ready", n), 256'(bus.in_ready), 256'(tbl[n].e_irdy));
            @(posedge clk);
            model_edge();
            #1;
            chk($sformatf("vec%0d out_valid", n), 256'(bus.out_valid), 256'(tbl[n].e_oval));
            chk($sformatf("vec%0d xfer_count", n), 256'(bus.xfer_count), 256'(tbl[n].e_cnt));
            chk($sformatf("vec%0d lane", n), 256'(bus.out_data[tbl[n].sel]), 256'(tbl[n].e_lane));
        end

        // Randomized traffic against the reference model.
        for (int n = 0; n < 400; n++) begin
            drive(($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)),
                  ($urandom_range(0, 7) == 0), $urandom, 8'($urandom));
            step(1'b1);
        end

        // Idle with unknown select must not disturb state.
        drive(1'b0, 3'bxxx, 1'b0, 32'hFFFF0000, 8'h00);
        step(1'b0);

        // Broadcast blocked by a single full, stalled lane.
        drive(1'b0, 3'd0, 1'b0, 32'h0, 8'hFF);
        step(1'b1);
        drive(1'b1, 3'd6, 1'b0, 32'h66666666, 8'h00);
        step(1'b1);
        drive(1'b1, 3'd0, 1'b1, 32'hDEADBEEF, 8'h00);
        #4;
        chk("bcast blocked in_ready", 256'(bus.in_ready), 256'h0);
        @(posedge clk); model_edge(); #1;
        chk("bcast blocked out_valid", 256'(bus.out_valid), 256'h40);
        chk("bcast blocked lane6", 256'(bus.out_data[6]), 256'h66666666);

        // Counter wrap: 256 accepts bring it back to the starting value.
        c0 = mcnt;
        for (int n = 0; n < 256; n++) begin
            drive(1'b1, 3'(n), (n % 5 == 0), 32'(n), 8'hFF);
            step(1'b1);
        end
        chk("wrap xfer_count", 256'(bus.xfer_count), 256'(c0));

        // Asynchronous reset between edges, with an accept pending.
        drive(1'b1, 3'd1, 1'b0, 32'h11111111, 8'h00);
        step(1'b1);
        drive(1'b1, 3'd4, 1'b0, 32'h44444444, 8'h00);
        step(1'b1);
        drive(1'b1, 3'd2, 1'b0, 32'h22222222, 8'h00);
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        chk("async rst out_valid", 256'(bus.out_valid), 256'h0);
        chk("async rst out_data", bus.out_data, 256'h0);
        chk("async rst xfer_count", 256'(bus.xfer_count), 256'h0);
        chk("async rst in_ready", 256'(bus.in_ready), 256'h1);
        @(posedge clk); #1;
        chk("rst held out_valid", 256'(bus.out_valid), 256'h0);
        chk("rst held xfer_count", 256'(bus.xfer_count), 256'h0);
        drive(1'b0, 3'd0, 1'b0, 32'h0, 8'h00);
        reset = 1'b0;
        drive(1'b1, 3'd7, 1'b0, 32'h77777777, 8'h00);
        step(1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
